// File: rtl/serial_adder.sv
// Bit-serial adder: sums two WIDTH-bit operands plus carry-in LSB-first,
// one bit per clock, through a single full-adder slice and a carry flop.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             carry;
  logic [CW-1:0]    count;
  logic             accept, last, s, c_next;

  // Full-adder slice on the current LSBs plus the control decodes.
  always_comb begin
    s      = a_sh[0] ^ b_sh[0] ^ carry;
    c_next = (a_sh[0] & b_sh[0]) | ((a_sh[0] ^ b_sh[0]) & carry);
    accept = start && (state != SHIFT);
    last   = (state == SHIFT) && (count == CW'(WIDTH - 1));
  end

  // Next-state logic: IDLE/DONE accept a request, SHIFT runs WIDTH edges.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (last)   state_next = DONE;
      DONE:    state_next = accept ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Datapath: operand/result shift registers, carry, bit counter, outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      carry  <= cin;
      count  <= '0;
    end else if (state == SHIFT) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      res_sh <= {s, res_sh[WIDTH-1:1]};
      carry  <= c_next;
      count  <= count + 1'b1;
      if (last) begin
        sum  <= {s, res_sh[WIDTH-1:1]};
        cout <= c_next;
      end
    end
  end

  // Status flags decode straight from the state register.
  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vector table, multi-cycle
// corner sequences at WIDTH=8, and a random sweep at WIDTH=8 and WIDTH=16.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, cin, busy, done, cout;
  logic [7:0]  a, b, sum;
  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;

  int unsigned total  = 0;
  int unsigned passed = 0;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation from IDLE; called #1 after a rising edge.
  task automatic op8(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                     input logic [7:0] es, input logic eco, input string name);
    logic [7:0] prev_s;
    logic       prev_c;
    int         k, busy_n;
    bit         stable;
    prev_s = sum;
    prev_c = cout;
    a = va; b = vb; cin = vc; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~va; b = ~vb; cin = ~vc;
    k = 0; busy_n = 0; stable = 1'b1;
    while (!done && k < 40) begin
      if (busy) busy_n++;
      if (sum !== prev_s || cout !== prev_c) stable = 1'b0;
      tick();
      k++;
    end
    chk($sformatf("%s latency", name), k, 8);
    chk($sformatf("%s busy_cycles", name), busy_n, 8);
    chk($sformatf("%s result", name), {cout, sum}, {eco, es});
    chk($sformatf("%s hold_during_shift", name), stable, 1);
    chk($sformatf("%s busy_in_done", name), busy, 0);
    tick();
    chk($sformatf("%s done_one_cycle", name), {busy, done}, 2'b00);
  endtask

  // One WIDTH=16 operation from IDLE; called #1 after a rising edge.
  task automatic op16(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    logic [16:0] exp;
    int          k;
    exp = {1'b0, va} + {1'b0, vb} + 17'(vc);
    a16 = va; b16 = vb; cin16 = vc; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    a16 = ~va; b16 = ~vb;
    k = 0;
    while (!done16 && k < 60) begin
      tick();
      k++;
    end
    chk("w16 latency", k, 16);
    chk("w16 result", {cout16, sum16}, exp);
    tick();
  endtask

  initial begin
    int k, ndone, bad;
    logic [7:0]  ra, rb;
    logic        rc;
    logic [8:0]  rexp;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
    vecs[8] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[9] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

    // Reset with start asserted: start must be ignored.
    rst_n = 1'b0; start = 1'b1; a = 8'h55; b = 8'h66; cin = 1'b1;
    start16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0;
    repeat (3) tick();
    chk("reset outputs", {busy, done, cout, sum}, '0);
    chk("reset outputs w16", {busy16, done16, cout16, sum16}, '0);
    start = 1'b0; start16 = 1'b0; rst_n = 1'b1;
    tick();
    chk("idle after reset", {busy, done}, 2'b00);

    for (int i = 0; i < 10; i++)
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, $sformatf("vec%0d", i));

    // Start pulsed mid-SHIFT is discarded.
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    a = 8'hAA; b = 8'h55; start = 1'b1;
    tick();
    start = 1'b0;
    k = 3;
    while (!done && k < 40) begin tick(); k++; end
    chk("ignore latency", k, 8);
    chk("ignore result", {cout, sum}, 9'h046);
    ndone = 0;
    repeat (14) begin tick(); if (done || busy) ndone++; end
    chk("ignore no second op", ndone, 0);
    chk("ignore sum held", {cout, sum}, 9'h046);

    // Start held high: back-to-back operations every WIDTH+1 cycles.
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    k = 0;
    while (!done && k < 40) begin tick(); k++; end
    chk("b2b first latency", k, 9);
    chk("b2b first result", {cout, sum}, 9'h100);
    for (int p = 0; p < 3; p++) begin
      k = 0; bad = 0;
      tick(); k++;
      if (busy == done) bad++;
      while (!done && k < 40) begin
        tick(); k++;
        if (busy == done) bad++;
      end
      chk($sformatf("b2b period %0d", p), k, 9);
      chk($sformatf("b2b result %0d", p), {cout, sum}, 9'h100);
      chk($sformatf("b2b busy_vs_done %0d", p), bad, 0);
    end
    start = 1'b0;
    tick();
    chk("b2b back to idle", {busy, done}, 2'b00);

    // Reset during SHIFT abandons the operation.
    a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("midreset busy before", busy, 1);
    rst_n = 1'b0;
    tick();
    chk("midreset outputs", {busy, done, cout, sum}, '0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin tick(); if (done || busy) ndone++; end
    chk("midreset no done", ndone, 0);
    op8(8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, "after_reset");

    // Random sweep against a + b + cin.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      rexp = {1'b0, ra} + {1'b0, rb} + 9'(rc);
      op8(ra, rb, rc, rexp[7:0], rexp[8], "rnd8");
    end
    for (int i = 0; i < 1000; i++)
      op16(16'($urandom), 16'($urandom), 1'($urandom));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
